// File: rtl/mem_arbiter.sv
// Single-port bus arbiter/sequencer shared by instruction fetch and the two memory-stage lanes.
// One transaction outstanding; a pending fetch is forced through after FAIR_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned FAIR_LIMIT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             if_req_i,
  input  logic [31:0]      if_addr_i,
  output logic             if_valid_o,
  output logic [31:0]      if_rdata_o,
  input  logic [1:0]       mem_req_i,
  input  logic [1:0]       mem_we_i,
  input  logic [1:0][3:0]  mem_be_i,
  input  logic [1:0][31:0] mem_addr_i,
  input  logic [1:0][31:0] mem_wdata_i,
  output logic [1:0][31:0] mem_rdata_o,
  output logic [1:0]       mem_done_o,
  output logic             stall_from_memory_o,
  output logic             bus_req_o,
  output logic             bus_we_o,
  output logic [3:0]       bus_be_o,
  output logic [31:0]      bus_addr_o,
  output logic [31:0]      bus_wdata_o,
  input  logic             bus_gnt_i,
  input  logic             bus_rvalid_i,
  input  logic [31:0]      bus_rdata_i
);

  localparam int unsigned CNT_W = (FAIR_LIMIT < 4) ? 2 : $clog2(FAIR_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(FAIR_LIMIT);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_RESP = 2'd2} state_e;
  typedef enum logic [1:0] {OWN_LANE0 = 2'd0, OWN_LANE1 = 2'd1, OWN_FETCH = 2'd2} owner_e;

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] fair_q, fair_d;
  logic             drop_q, drop_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic             if_valid_q, if_valid_d;
  logic [31:0]      if_rdata_q, if_rdata_d;
  logic [1:0]       done_q, done_d;
  logic [1:0][31:0] rdata_q, rdata_d;

  logic [1:0] pend_s;
  logic       stall_s, fetch_ok_s, fair_hit_s, lane_sel_s, lane_own_s, drop_now_s;

  function automatic logic [CNT_W-1:0] fair_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= CNT_LIMIT) begin
      return CNT_LIMIT;
    end else begin
      return cnt + CNT_W'(1);
    end
  endfunction

  assign pend_s     = mem_req_i & ~done_q;
  assign stall_s    = |pend_s;
  assign fetch_ok_s = if_req_i & ~flush_i;
  assign fair_hit_s = (fair_q == CNT_LIMIT) & fetch_ok_s;
  assign lane_sel_s = ~pend_s[0];
  assign lane_own_s = owner_q[0];
  // A flush in the same cycle as the fetch response still discards it.
  assign drop_now_s = drop_q | flush_i;

  // Arbitration, bus sequencing and per-lane completion next-state.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    fair_d      = if_req_i ? fair_q : {CNT_W{1'b0}};
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_be_d    = bus_be_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    if_valid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    rdata_d     = rdata_q;
    done_d      = stall_s ? done_q : 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (fair_hit_s || (fetch_ok_s && !stall_s)) begin
          state_d     = ST_ADDR;
          owner_d     = OWN_FETCH;
          fair_d      = {CNT_W{1'b0}};
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_be_d    = 4'hF;
          bus_addr_d  = if_addr_i;
          bus_wdata_d = 32'h0000_0000;
        end else if (stall_s) begin
          state_d     = ST_ADDR;
          owner_d     = lane_sel_s ? OWN_LANE1 : OWN_LANE0;
          fair_d      = if_req_i ? fair_inc(fair_q) : {CNT_W{1'b0}};
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we_i[lane_sel_s];
          bus_be_d    = mem_be_i[lane_sel_s];
          bus_addr_d  = mem_addr_i[lane_sel_s];
          bus_wdata_d = mem_wdata_i[lane_sel_s];
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        drop_d = drop_q | (flush_i && (owner_q == OWN_FETCH));
        if (bus_gnt_i) begin
          bus_req_d = 1'b0;
          state_d   = ST_RESP;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_RESP: begin
        if (bus_rvalid_i) begin
          state_d = ST_IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_FETCH) begin
            if_valid_d = ~drop_now_s;
            if_rdata_d = drop_now_s ? if_rdata_q : bus_rdata_i;
          end else begin
            done_d[lane_own_s]  = 1'b1;
            rdata_d[lane_own_s] = bus_we_q ? rdata_q[lane_own_s] : bus_rdata_i;
          end
        end else begin
          drop_d = drop_q | (flush_i && (owner_q == OWN_FETCH));
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_LANE0;
      fair_q      <= {CNT_W{1'b0}};
      drop_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_be_q    <= 4'h0;
      bus_addr_q  <= 32'h0000_0000;
      bus_wdata_q <= 32'h0000_0000;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= 32'h0000_0000;
      done_q      <= 2'b00;
      rdata_q     <= {2{32'h0000_0000}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      fair_q      <= fair_d;
      drop_q      <= drop_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_be_q    <= bus_be_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
    end
  end

  assign stall_from_memory_o = stall_s;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_be_o    = bus_be_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_done_o  = done_q;
  assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: bus responder model, transaction scoreboard,
// a table of single transactions and directed multi-cycle sequences.
module tb_mem_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             if_req;
  logic [31:0]      if_addr;
  logic             if_valid;
  logic [31:0]      if_rdata;
  logic [1:0]       mem_req;
  logic [1:0]       mem_we;
  logic [1:0][3:0]  mem_be;
  logic [1:0][31:0] mem_addr;
  logic [1:0][31:0] mem_wdata;
  logic [1:0][31:0] mem_rdata;
  logic [1:0]       mem_done;
  logic             stall;
  logic             bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [3:0]       bus_be;
  logic [31:0]      bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.FAIR_LIMIT(3)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_valid_o(if_valid), .if_rdata_o(if_rdata),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_be_i(mem_be), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .stall_from_memory_o(stall),
    .bus_req_o(bus_req), .bus_we_o(bus_we), .bus_be_o(bus_be), .bus_addr_o(bus_addr),
    .bus_wdata_o(bus_wdata), .bus_gnt_i(bus_gnt), .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    else return a ^ 32'hA5A5_5A5A;
  endfunction

  // Bus responder: grant after gnt_delay cycles of bus_req, respond the cycle after grant.
  logic [3:0]  gnt_delay;
  logic [3:0]  wait_q;
  logic        pend_q;
  logic [31:0] pend_addr_q;
  assign bus_gnt    = bus_req && (wait_q == gnt_delay);
  assign bus_rvalid = pend_q;
  assign bus_rdata  = pend_q ? rd_model(pend_addr_q) : 32'h0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_q <= 4'd0; pend_q <= 1'b0; pend_addr_q <= 32'h0;
    end else begin
      pend_q <= bus_gnt;
      if (bus_gnt) pend_addr_q <= bus_addr;
      if (bus_req && !bus_gnt) wait_q <= wait_q + 4'd1;
      else wait_q <= 4'd0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        full;
  } bus_t;

  typedef struct {
    logic        fetch;
    logic        lane;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  bus_t        exp_bus_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_l0_q[$];
  logic [31:0] exp_l1_q[$];
  vec_t        vecs[6];

  int checks = 0;
  int errors = 0;
  int cyc, ifv_cyc, done0_cyc, done1_cyc, done_fall_cyc, stall_cnt, stall_last, bus_req_cnt;
  logic [1:0] done_prev = 2'b00;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                          input logic [31:0] wd, input logic full);
    bus_t b;
    b.addr = a; b.we = we; b.be = be; b.wdata = wd; b.full = full;
    exp_bus_q.push_back(b);
  endtask

  task automatic monitor();
    bus_t b;
    if (bus_req) begin
      bus_req_cnt++;
      if (exp_bus_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL bus_unexpected: got addr %h expected no transaction", bus_addr);
      end else begin
        b = exp_bus_q[0];
        check32("bus_addr", bus_addr, b.addr);
        check32("bus_we", {31'd0, bus_we}, {31'd0, b.we});
        if (b.full) begin
          check32("bus_be", {28'd0, bus_be}, {28'd0, b.be});
          check32("bus_wdata", bus_wdata, b.wdata);
        end
        if (bus_gnt) void'(exp_bus_q.pop_front());
      end
    end
    if (if_valid) begin
      ifv_cyc = cyc;
      if (exp_if_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_valid_unexpected: got data %h expected no pulse", if_rdata);
      end else check32("if_rdata", if_rdata, exp_if_q.pop_front());
    end
    if (mem_done[0] && !done_prev[0]) begin
      done0_cyc = cyc;
      if (exp_l0_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL lane0_unexpected: got done expected none");
      end else check32("mem_rdata0", mem_rdata[0], exp_l0_q.pop_front());
    end
    if (mem_done[1] && !done_prev[1]) begin
      done1_cyc = cyc;
      if (exp_l1_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL lane1_unexpected: got done expected none");
      end else check32("mem_rdata1", mem_rdata[1], exp_l1_q.pop_front());
    end
    if (done_prev != 2'b00 && mem_done == 2'b00) done_fall_cyc = cyc;
    if (stall) begin
      stall_cnt++;
      stall_last = cyc;
    end
    done_prev = mem_done;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_trk();
    cyc = 0; ifv_cyc = -1; done0_cyc = -1; done1_cyc = -1; done_fall_cyc = -1;
    stall_cnt = 0; stall_last = -1; bus_req_cnt = 0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check32({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
    check32({tag, "_bus_we"}, {31'd0, bus_we}, 32'd0);
    check32({tag, "_bus_be"}, {28'd0, bus_be}, 32'd0);
    check32({tag, "_bus_addr"}, bus_addr, 32'd0);
    check32({tag, "_bus_wdata"}, bus_wdata, 32'd0);
    check32({tag, "_if_valid"}, {31'd0, if_valid}, 32'd0);
    check32({tag, "_if_rdata"}, if_rdata, 32'd0);
    check32({tag, "_mem_done"}, {30'd0, mem_done}, 32'd0);
    check32({tag, "_mem_rdata0"}, mem_rdata[0], 32'd0);
    check32({tag, "_mem_rdata1"}, mem_rdata[1], 32'd0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; flush = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    mem_req = 2'b00; mem_we = 2'b00; mem_be = '0; mem_addr = '0; mem_wdata = '0;
    gnt_delay = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check32("reset_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // Single fetch after reset: if_valid at cycle 3, no stall.
    clear_trk();
    if_req = 1'b1; if_addr = 32'h0000_0100;
    push_bus(32'h0000_0100, 1'b0, 4'hF, 32'h0, 1'b0);
    exp_if_q.push_back(32'hDEAD_BEEF);
    for (int c = 0; c < 8; c++) begin
      if (c == 1) if_req = 1'b0;
      step();
    end
    check_int("fetch_latency", ifv_cyc, 3);
    check_int("fetch_no_stall", stall_cnt, 0);

    // Table of isolated transactions, zero-wait bus.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 4'hF, 32'h0000_0010, 32'h0, rd_model(32'h0000_0010)};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0014, 32'h0, rd_model(32'h0000_0014)};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 4'hC, 32'h0000_0018, 32'hCAFE_0000, rd_model(32'h0000_0014)};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'h0000_0020, 32'h0, rd_model(32'h0000_0020)};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 4'h8, 32'h0000_001C, 32'h0000_0011, rd_model(32'h0000_0010)};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, rd_model(32'hFFFF_FFFC)};
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      clear_trk();
      if (v.fetch) begin
        if_req = 1'b1; if_addr = v.addr;
        push_bus(v.addr, 1'b0, 4'hF, 32'h0, 1'b0);
        exp_if_q.push_back(v.exp_rdata);
      end else begin
        mem_req = v.lane ? 2'b10 : 2'b01;
        mem_we = v.we ? mem_req : 2'b00;
        mem_be[v.lane] = v.be; mem_addr[v.lane] = v.addr; mem_wdata[v.lane] = v.wdata;
        push_bus(v.addr, v.we, v.be, v.wdata, 1'b1);
        if (v.lane) exp_l1_q.push_back(v.exp_rdata);
        else exp_l0_q.push_back(v.exp_rdata);
      end
      for (int c = 0; c < 7; c++) begin
        if (c == 1) if_req = 1'b0;
        if (c == 4) begin mem_req = 2'b00; mem_we = 2'b00; end
        step();
      end
      check_int($sformatf("vec%0d_latency", i),
                v.fetch ? ifv_cyc : (v.lane ? done1_cyc : done0_cyc), 3);
    end

    // Two-lane load bundle with a fetch pending: order L0, L1, FETCH.
    clear_trk();
    mem_req = 2'b11; mem_we = 2'b00; mem_be = {4'hF, 4'hF};
    mem_addr[0] = 32'h0000_0200; mem_addr[1] = 32'h0000_0204; mem_wdata = '0;
    if_req = 1'b1; if_addr = 32'h0000_0300;
    push_bus(32'h0000_0200, 1'b0, 4'hF, 32'h0, 1'b1);
    push_bus(32'h0000_0204, 1'b0, 4'hF, 32'h0, 1'b1);
    push_bus(32'h0000_0300, 1'b0, 4'hF, 32'h0, 1'b0);
    exp_l0_q.push_back(rd_model(32'h0000_0200));
    exp_l1_q.push_back(rd_model(32'h0000_0204));
    exp_if_q.push_back(rd_model(32'h0000_0300));
    for (int c = 0; c < 12; c++) begin
      if (c == 7) begin mem_req = 2'b00; if_req = 1'b0; end
      step();
    end
    check_int("bundle_stall_cycles", stall_cnt, 6);
    check_int("bundle_stall_last", stall_last, 5);
    check_int("bundle_done0_cyc", done0_cyc, 3);
    check_int("bundle_done1_cyc", done1_cyc, 6);
    check_int("bundle_done_clear", done_fall_cyc, 7);
    check_int("bundle_fetch_cyc", ifv_cyc, 9);

    // Lane0 store with grant delayed 3 cycles: bus held stable, rdata unchanged.
    clear_trk();
    gnt_delay = 4'd3;
    mem_req = 2'b01; mem_we = 2'b01; mem_be[0] = 4'b0011;
    mem_addr[0] = 32'h0000_0400; mem_wdata[0] = 32'h1234_ABCD;
    push_bus(32'h0000_0400, 1'b1, 4'b0011, 32'h1234_ABCD, 1'b1);
    exp_l0_q.push_back(rd_model(32'h0000_0200));
    for (int c = 0; c < 10; c++) begin
      if (c == 7) begin mem_req = 2'b00; mem_we = 2'b00; end
      step();
    end
    check_int("store_addr_cycles", bus_req_cnt, 4);
    check_int("store_done_cyc", done0_cyc, 6);
    gnt_delay = 4'd0;

    // Flush while a fetch is in RESP: response dropped, redirected fetch returns.
    clear_trk();
    if_req = 1'b1; if_addr = 32'h0000_0500;
    push_bus(32'h0000_0500, 1'b0, 4'hF, 32'h0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c == 2) begin
        flush = 1'b1; if_addr = 32'h0000_0600;
        push_bus(32'h0000_0600, 1'b0, 4'hF, 32'h0, 1'b0);
        exp_if_q.push_back(rd_model(32'h0000_0600));
      end
      if (c == 3) flush = 1'b0;
      if (c == 4) if_req = 1'b0;
      step();
    end
    check_int("flush_refetch_cyc", ifv_cyc, 6);

    // Fairness: three data grants with if_req held (fetch blocked by flush) force the fetch ahead of lane1.
    clear_trk();
    mem_req = 2'b11; mem_we = 2'b00; mem_be = {4'hF, 4'hF}; mem_wdata = '0;
    mem_addr[0] = 32'h0000_0700; mem_addr[1] = 32'h0000_0704;
    if_req = 1'b1; if_addr = 32'h0000_0800; flush = 1'b1;
    push_bus(32'h0000_0700, 1'b0, 4'hF, 32'h0, 1'b1);
    push_bus(32'h0000_0704, 1'b0, 4'hF, 32'h0, 1'b1);
    exp_l0_q.push_back(rd_model(32'h0000_0700));
    exp_l1_q.push_back(rd_model(32'h0000_0704));
    for (int c = 0; c < 20; c++) begin
      if (c == 7) begin
        mem_addr[0] = 32'h0000_0710; mem_addr[1] = 32'h0000_0714;
        push_bus(32'h0000_0710, 1'b0, 4'hF, 32'h0, 1'b1);
        push_bus(32'h0000_0800, 1'b0, 4'hF, 32'h0, 1'b0);
        push_bus(32'h0000_0714, 1'b0, 4'hF, 32'h0, 1'b1);
        exp_l0_q.push_back(rd_model(32'h0000_0710));
        exp_l1_q.push_back(rd_model(32'h0000_0714));
        exp_if_q.push_back(rd_model(32'h0000_0800));
      end
      if (c == 8) flush = 1'b0;
      if (c == 11) if_req = 1'b0;
      if (c == 17) mem_req = 2'b00;
      step();
    end
    check_int("fair_fetch_cyc", ifv_cyc, 13);
    check_int("fair_lane1_cyc", done1_cyc, 16);

    // Reset while a lane0 read is in RESP.
    clear_trk();
    mem_req = 2'b01; mem_addr[0] = 32'h0000_0900;
    push_bus(32'h0000_0900, 1'b0, 4'hF, 32'h0, 1'b1);
    exp_l0_q.push_back(rd_model(32'h0000_0900));
    step();
    step();
    rst = 1'b1;
    #1;
    check_outputs_zero("midrst");
    exp_l0_q.delete();
    exp_bus_q.delete();
    mem_req = 2'b00;
    step();
    step();
    rst = 1'b0;
    clear_trk();
    mem_req = 2'b11; mem_we = 2'b10; mem_be = {4'hF, 4'hF};
    mem_addr[0] = 32'h0000_0A00; mem_addr[1] = 32'h0000_0A04; mem_wdata[1] = 32'h55AA_55AA;
    push_bus(32'h0000_0A00, 1'b0, 4'hF, 32'h0, 1'b1);
    push_bus(32'h0000_0A04, 1'b1, 4'hF, 32'h55AA_55AA, 1'b1);
    exp_l0_q.push_back(rd_model(32'h0000_0A00));
    exp_l1_q.push_back(32'h0000_0000);
    for (int c = 0; c < 10; c++) begin
      if (c == 7) begin mem_req = 2'b00; mem_we = 2'b00; end
      step();
    end
    check_int("postrst_done1_cyc", done1_cyc, 6);

    check_int("left_bus", exp_bus_q.size(), 0);
    check_int("left_fetch", exp_if_q.size(), 0);
    check_int("left_lane0", exp_l0_q.size(), 0);
    check_int("left_lane1", exp_l1_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
